maxpool_layer_ctrl: RTL and testbench
=====================================

// Module: maxpool_layer_ctrl
// PURPOSE
//  Per-layer sequencer placed in front of the 2x2 maxpool engine. It accepts one layer
//  config per handshake, forwards the input stream with the ready/valid handshake gated,
//  and generates the constant per-layer s_user tag and a last-beat flag. It waits for the
//  engine pipeline to drain before it accepts the next config, and rejects illegal configs.
// PARAMETERS
//  MEMBERS        8   beats per block (KERNEL_W_MAX*MEMBERS beats when kernel_h_1==0)
//  KERNEL_W_MAX   3   max kernel width
//  BITS_KERNEL_H  2   width of kernel_h_1 field
//  BITS_BLOCKS    16  width of block count
//  TUSER_WIDTH    4   width of m_user (== TUSER_WIDTH_MAXPOOL_IN)
//  I_IS_NOT_MAX   0   m_user bit: emit non-max data
//  I_IS_MAX       1   m_user bit: emit max data
//  I_KERNEL_H_1   2   m_user LSB of kernel_h_1 field
//  DRAIN_CYCLES   3   idle cycles after last beat before next config (engine latency 2, +1 margin)
// PORTS
//  clk             in   1            clock
//  reset           in   1            synchronous, active-high reset
//  clken           in   1            global clock enable; when 0, no register updates
//  cfg_valid       in   1            config valid
//  cfg_ready       out  1            config accepted (only in IDLE)
//  cfg_is_max      in   1            layer needs maxpool output
//  cfg_is_not_max  in   1            layer needs non-max output
//  cfg_kernel_h_1  in   BITS_KERNEL_H  kernel height - 1 (0 = 1x1)
//  cfg_blocks_1    in   BITS_BLOCKS  number of blocks in layer - 1
//  cfg_err         out  1            one-cycle pulse when a config is rejected
//  s_valid/s_ready in/out 1          upstream stream handshake
//  m_valid/m_ready out/in 1          handshake toward the engine (engine s_ready)
//  m_user          out  TUSER_WIDTH  layer tag; other bits 0
//  m_last_in       out  1            high on the final input beat of the layer
//  busy            out  1            state != IDLE
//  perf_stall      out  32           stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; counters, m_user, cfg_err, perf_stall=0; cfg_ready=1; busy=0.
//  FSM: IDLE -> RUN on cfg handshake (legal cfg); RUN -> DRAIN on last beat handshake;
//   DRAIN -> IDLE after DRAIN_CYCLES clken cycles.
//  Illegal cfg (held in IDLE, still handshaken so upstream is not blocked, cfg_err=1 next cycle):
//   is_max==0 && is_not_max==0; is_max && kernel_h_1==0; is_max && cfg_blocks_1 even (odd block count).
//  Accepted cfg: fields registered, so m_user is stable for the whole layer.
//  Stream: m_valid = s_valid && state==RUN; s_ready = m_ready && state==RUN; combinational,
//   zero latency; the data bus bypasses this block.
//  Counters advance on handshake: beat_cnt 0..ref-1, with ref = MEMBERS when kernel_h_1!=0,
//   otherwise KERNEL_W_MAX*MEMBERS. On wrap, block_cnt+1.
//  m_last_in = (beat_cnt==ref-1) && (block_cnt==cfg_blocks_1) && state==RUN.
//  Engine back-pressure (m_ready low for 1 cycle in MAX_4 phase) only stalls; no beat is lost.
//  Reset mid-layer: return to IDLE immediately; counters cleared; partial layer is discarded.
//  cfg_valid during RUN/DRAIN: ignored, cfg_ready=0.
// CONFIGURATION
//  MAXPOOL_LAYER_CTRL_PERF_EN defined: perf_stall counts cycles with state==RUN && s_valid &&
//   !m_ready. It saturates at 2^32-1 and clears when a config is accepted.
//  Not defined: perf_stall tied to 0 and no counter logic is built.
// TESTING
//  Reset, then cfg {max=0,not_max=1,kh_1=2,blocks_1=1}, stream 16 beats with m_ready=1 ->
//   16 handshakes; m_user=0b1001; m_last_in only on beat 16; busy low 3 cycles later.
//  cfg {max=1,not_max=1,kh_1=2,blocks_1=1}; m_ready low every 2nd cycle during beats 9-16 ->
//   all 16 beats pass, with stall cycles only; m_last_in on beat 16.
//  cfg {max=0,not_max=1,kh_1=0,blocks_1=0} -> 24 beats; m_last_in on beat 24.
//  cfg {max=1,kh_1=0} and cfg {max=1,blocks_1=0} -> cfg_err pulses; busy stays 0; s_ready=0.
//  Assert reset at beat 5 of a 16-beat layer -> IDLE next cycle; s_ready=0; new cfg accepted.
//  PERF_EN build: 4 stall cycles in a layer -> perf_stall=4; next cfg clears it to 0.

Source files
------------

// File: rtl/maxpool_layer_ctrl.sv
// Per-layer sequencer in front of the 2x2 maxpool engine: config handshake, gated stream, tag, last flag.
// Optional stall counter built only when MAXPOOL_LAYER_CTRL_PERF_EN is defined.
module maxpool_layer_ctrl #(
    parameter int MEMBERS       = 8,
    parameter int KERNEL_W_MAX  = 3,
    parameter int BITS_KERNEL_H = 2,
    parameter int BITS_BLOCKS   = 16,
    parameter int TUSER_WIDTH   = 4,
    parameter int I_IS_NOT_MAX  = 0,
    parameter int I_IS_MAX      = 1,
    parameter int I_KERNEL_H_1  = 2,
    parameter int DRAIN_CYCLES  = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clken,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic                     i_cfg_is_max,
    input  logic                     i_cfg_is_not_max,
    input  logic [BITS_KERNEL_H-1:0] i_cfg_kernel_h_1,
    input  logic [BITS_BLOCKS-1:0]   i_cfg_blocks_1,
    output logic                     o_cfg_err,
    input  logic                     i_s_valid,
    output logic                     o_s_ready,
    output logic                     o_m_valid,
    input  logic                     i_m_ready,
    output logic [TUSER_WIDTH-1:0]   o_m_user,
    output logic                     o_m_last_in,
    output logic                     o_busy,
    output logic [31:0]              o_perf_stall
);

    localparam int BEATS_MAX = KERNEL_W_MAX * MEMBERS;
    localparam int BEAT_W    = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
    localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 1);

    localparam logic [BEAT_W-1:0]      BEAT_ONE  = BEAT_W'(1);
    localparam logic [BITS_BLOCKS-1:0] BLK_ONE   = BITS_BLOCKS'(1);
    localparam logic [DRAIN_W-1:0]     DRAIN_ONE = DRAIN_W'(1);
    localparam logic [BEAT_W-1:0]      LAST_BEAT_TALL = BEAT_W'(MEMBERS - 1);
    localparam logic [BEAT_W-1:0]      LAST_BEAT_FLAT = BEAT_W'(BEATS_MAX - 1);
    localparam logic [DRAIN_W-1:0]     LAST_DRAIN     = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [BEAT_W-1:0]        r_beat_cnt;
    logic [BITS_BLOCKS-1:0]   r_block_cnt;
    logic [DRAIN_W-1:0]       r_drain_cnt;
    logic [BITS_BLOCKS-1:0]   r_blocks_1;
    logic [BITS_KERNEL_H-1:0] r_kernel_h_1;
    logic [TUSER_WIDTH-1:0]   r_m_user;
    logic                     r_cfg_err;

    logic                     w_cfg_hs;
    logic                     w_cfg_legal;
    logic                     w_accept;
    logic                     w_beat_hs;
    logic                     w_beat_wrap;
    logic                     w_layer_last;
    logic                     w_drain_done;
    logic [BEAT_W-1:0]        w_last_beat;
    logic [TUSER_WIDTH-1:0]   w_cfg_user;

    // Illegal configs are still handshaken so upstream never stalls on them.
    assign w_cfg_hs    = i_cfg_valid && (r_state == S_IDLE);
    assign w_cfg_legal = (i_cfg_is_max || i_cfg_is_not_max)
                      && !(i_cfg_is_max && (i_cfg_kernel_h_1 == '0))
                      && !(i_cfg_is_max && !i_cfg_blocks_1[0]);
    assign w_accept    = w_cfg_hs && w_cfg_legal;

    assign w_beat_hs    = i_s_valid && i_m_ready && (r_state == S_RUN);
    assign w_last_beat  = (r_kernel_h_1 != '0) ? LAST_BEAT_TALL : LAST_BEAT_FLAT;
    assign w_beat_wrap  = (r_beat_cnt == w_last_beat);
    assign w_layer_last = w_beat_wrap && (r_block_cnt == r_blocks_1);
    assign w_drain_done = (r_drain_cnt == LAST_DRAIN);

    always_comb begin
        w_cfg_user = '0;
        w_cfg_user[I_IS_NOT_MAX] = i_cfg_is_not_max;
        w_cfg_user[I_IS_MAX]     = i_cfg_is_max;
        w_cfg_user[I_KERNEL_H_1 +: BITS_KERNEL_H] = i_cfg_kernel_h_1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else if (i_clken) begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        o_cfg_ready  = 1'b0;
        o_busy       = 1'b1;
        o_s_ready    = 1'b0;
        o_m_valid    = 1'b0;
        o_m_last_in  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_cfg_ready = 1'b1;
                o_busy      = 1'b0;
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                o_s_ready   = i_m_ready;
                o_m_valid   = i_s_valid;
                o_m_last_in = w_layer_last;
                if (w_beat_hs && w_layer_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drain_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_beat_cnt   <= '0;
            r_block_cnt  <= '0;
            r_drain_cnt  <= '0;
            r_blocks_1   <= '0;
            r_kernel_h_1 <= '0;
            r_m_user     <= '0;
            r_cfg_err    <= 1'b0;
        end else if (i_clken) begin
            r_cfg_err <= w_cfg_hs && !w_cfg_legal;
            if (w_accept) begin
                r_blocks_1   <= i_cfg_blocks_1;
                r_kernel_h_1 <= i_cfg_kernel_h_1;
                r_m_user     <= w_cfg_user;
                r_beat_cnt   <= '0;
                r_block_cnt  <= '0;
            end else if (w_beat_hs) begin
                if (w_layer_last) begin
                    r_beat_cnt  <= '0;
                    r_block_cnt <= '0;
                end else if (w_beat_wrap) begin
                    r_beat_cnt  <= '0;
                    r_block_cnt <= r_block_cnt + BLK_ONE;
                end else begin
                    r_beat_cnt  <= r_beat_cnt + BEAT_ONE;
                end
            end
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DRAIN_ONE : '0;
        end
    end

    assign o_m_user  = r_m_user;
    assign o_cfg_err = r_cfg_err;

`ifdef MAXPOOL_LAYER_CTRL_PERF_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_stall <= '0;
        end else if (i_clken) begin
            if (w_accept) begin
                r_perf_stall <= '0;
            end else if ((r_state == S_RUN) && i_s_valid && !i_m_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_stall = r_perf_stall;
`else
    assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_maxpool_layer_ctrl.sv
// Self-checking bench for maxpool_layer_ctrl: random stream/back-pressure against a beat-counting model.
module tb_maxpool_layer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_is_max;
    logic        cfg_is_not_max;
    logic [1:0]  cfg_kernel_h_1;
    logic [15:0] cfg_blocks_1;
    logic        cfg_err;
    logic        s_valid;
    logic        s_ready;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_user;
    logic        m_last_in;
    logic        busy;
    logic [31:0] perf_stall;

    int checks = 0;
    int errors = 0;

    // Reference model state: a layer is "total" beats long, followed by a fixed drain window.
    bit          mdl_running;
    int          mdl_done;
    int          mdl_total;
    int          mdl_drain;
    logic [3:0]  mdl_user;
    logic        mdl_err;
    logic [31:0] mdl_perf;
    int          obs_hs;

    always #5 clk = ~clk;

    maxpool_layer_ctrl dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_clken          (clken),
        .i_cfg_valid      (cfg_valid),
        .o_cfg_ready      (cfg_ready),
        .i_cfg_is_max     (cfg_is_max),
        .i_cfg_is_not_max (cfg_is_not_max),
        .i_cfg_kernel_h_1 (cfg_kernel_h_1),
        .i_cfg_blocks_1   (cfg_blocks_1),
        .o_cfg_err        (cfg_err),
        .i_s_valid        (s_valid),
        .o_s_ready        (s_ready),
        .o_m_valid        (m_valid),
        .i_m_ready        (m_ready),
        .o_m_user         (m_user),
        .o_m_last_in      (m_last_in),
        .o_busy           (busy),
        .o_perf_stall     (perf_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_running = 1'b0;
        mdl_done    = 0;
        mdl_total   = 0;
        mdl_drain   = 0;
        mdl_user    = '0;
        mdl_err     = 1'b0;
        mdl_perf    = '0;
    endtask

    function automatic bit cfg_legal(input logic mx, input logic nm, input logic [1:0] kh,
                                     input logic [15:0] b1);
        return (mx || nm) && !(mx && kh == 0) && !(mx && (b1 % 2 == 0));
    endfunction

    // One clock: drive at the falling edge, check outputs, then advance the model across the rising edge.
    task automatic tick(input logic cv, input logic mx, input logic nm, input logic [1:0] kh,
                        input logic [15:0] b1, input logic sv, input logic mr, input logic rst);
        bit exp_busy;
        logic [31:0] exp_perf;
        cfg_valid      = cv;
        cfg_is_max     = mx;
        cfg_is_not_max = nm;
        cfg_kernel_h_1 = kh;
        cfg_blocks_1   = b1;
        s_valid        = sv;
        m_ready        = mr;
        reset          = rst;
        #1;
        exp_busy = mdl_running || (mdl_drain > 0);
`ifdef MAXPOOL_LAYER_CTRL_PERF_EN
        exp_perf = mdl_perf;
`else
        exp_perf = '0;
`endif
        check("busy",      {31'd0, busy},      {31'd0, exp_busy});
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !exp_busy});
        check("s_ready",   {31'd0, s_ready},   {31'd0, mdl_running && mr});
        check("m_valid",   {31'd0, m_valid},   {31'd0, mdl_running && sv});
        check("m_last_in", {31'd0, m_last_in}, {31'd0, mdl_running && (mdl_done == mdl_total - 1)});
        check("m_user",    {28'd0, m_user},    {28'd0, mdl_user});
        check("cfg_err",   {31'd0, cfg_err},   {31'd0, mdl_err});
        check("perf",      perf_stall,         exp_perf);
        if (sv && s_ready) obs_hs++;

        if (rst) begin
            model_reset();
        end else begin
            mdl_err = 1'b0;
            if (!exp_busy) begin
                if (cv) begin
                    if (cfg_legal(mx, nm, kh, b1)) begin
                        mdl_running = 1'b1;
                        mdl_done    = 0;
                        mdl_total   = (int'(b1) + 1) * ((kh != 0) ? 8 : 24);
                        mdl_user    = {kh, mx, nm};
                        mdl_perf    = '0;
                    end else begin
                        mdl_err = 1'b1;
                    end
                end
            end else if (mdl_running) begin
                if (sv && !mr && mdl_perf != 32'hFFFF_FFFF) mdl_perf = mdl_perf + 1;
                if (sv && mr) begin
                    mdl_done++;
                    if (mdl_done == mdl_total) begin
                        mdl_running = 1'b0;
                        mdl_drain   = 3;
                    end
                end
            end else begin
                mdl_drain--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // mode 0: m_ready high; 1: m_ready toggles once 8 beats are in; 2: random m_ready.
    // abort_at >= 0 asserts reset while beat abort_at+1 is being offered.
    task automatic run_layer(input logic mx, input logic nm, input logic [1:0] kh,
                             input logic [15:0] b1, input int mode, input int abort_at);
        int  cyc;
        bit  aborted;
        logic sv, mr;
        cyc     = 0;
        aborted = 1'b0;
        obs_hs  = 0;
        tick(1'b1, mx, nm, kh, b1, 1'b0, 1'b1, 1'b0);
        while ((mdl_running || mdl_drain > 0) && cyc < 2000) begin
            if (abort_at >= 0 && mdl_running && mdl_done == abort_at) begin
                tick(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b1);
                aborted = 1'b1;
                break;
            end
            sv = ($urandom_range(0, 3) != 0);
            case (mode)
                1:       mr = (mdl_done >= 8) ? cyc[0] : 1'b1;
                2:       mr = 1'($urandom_range(0, 1));
                default: mr = 1'b1;
            endcase
            // Configs offered while busy must be ignored.
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 5)), sv, mr, 1'b0);
            cyc++;
        end
        check("layer_timeout", {31'd0, cyc < 2000}, 32'd1);
        if (!aborted && cfg_legal(mx, nm, kh, b1))
            check("handshakes", obs_hs, (int'(b1) + 1) * ((kh != 0) ? 8 : 24));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clken = 1'b1;
        cfg_valid = 1'b0;
        cfg_is_max = 1'b0;
        cfg_is_not_max = 1'b0;
        cfg_kernel_h_1 = '0;
        cfg_blocks_1 = '0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        model_reset();
        obs_hs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        idle_tick();

        // 16-beat non-max layer with free-flowing engine.
        run_layer(1'b0, 1'b1, 2'd2, 16'd1, 0, -1);
        check("user_layer1", {28'd0, m_user}, 32'b1001);
        idle_tick();

        // Same geometry, max + non-max, engine back-pressure in the second block.
        run_layer(1'b1, 1'b1, 2'd2, 16'd1, 1, -1);
        check("user_layer2", {28'd0, m_user}, 32'b1011);

        // 1x1 kernel: one block is KERNEL_W_MAX*MEMBERS = 24 beats.
        run_layer(1'b0, 1'b1, 2'd0, 16'd0, 0, -1);

        // Illegal configs: max with 1x1 kernel, max with odd block count, no output at all.
        tick(1'b1, 1'b1, 1'b0, 2'd0, 16'd1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 2'd2, 16'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd1, 16'd3, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        check("err_cleared", {31'd0, cfg_err}, 32'd0);

        // Reset while beat 5 of a 16-beat layer is offered, then a fresh layer.
        run_layer(1'b0, 1'b1, 2'd2, 16'd1, 0, 4);
        check("abort_user", {28'd0, m_user}, 32'd0);
        idle_tick();
        run_layer(1'b1, 1'b0, 2'd1, 16'd3, 2, -1);

        // Random configs under random back-pressure.
        for (int i = 0; i < 4; i++) begin
            run_layer(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)),
                      16'($urandom_range(0, 4) | 1), 2, -1);
            idle_tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
